// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared constants for the ROM -> coprocessor -> frame-buffer -> VGA image
// path: image dimensions for every supported zoom level, default sizes for
// the sequencer, address width and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package img_pkg;

  // Image dimensions, smallest (20x15) to full VGA (640x480).
  localparam int IMG_20_W  = 20;   localparam int IMG_20_H  = 15;
  localparam int IMG_40_W  = 40;   localparam int IMG_40_H  = 30;
  localparam int IMG_80_W  = 80;   localparam int IMG_80_H  = 60;
  localparam int IMG_160_W = 160;  localparam int IMG_160_H = 120;
  localparam int IMG_320_W = 320;  localparam int IMG_320_H = 240;
  localparam int IMG_640_W = 640;  localparam int IMG_640_H = 480;

  // Sequencer defaults: 160x120 source in ROM, 640x480 frame buffer.
  localparam int DEF_ADDR_W         = 19;
  localparam int DEF_SRC_PIXELS     = IMG_160_W * IMG_160_H;
  localparam int DEF_MAX_OUT_PIXELS = IMG_640_W * IMG_640_H;
  localparam int DEF_SETTLE_CYCLES  = 15;

  // Coprocessor stall watchdog width (only used with SEQ_WATCHDOG_EN).
  localparam int WDOG_W = 24;

  // State encoding, visible on seq_state for debug LEDs.
  localparam logic [2:0] SEQ_SETTLE  = 3'd0;
  localparam logic [2:0] SEQ_FEED    = 3'd1;
  localparam logic [2:0] SEQ_DRAIN   = 3'd2;
  localparam logic [2:0] SEQ_DISPLAY = 3'd3;
  localparam logic [2:0] SEQ_BYPASS  = 3'd4;
  localparam logic [2:0] SEQ_ERROR   = 3'd5;

  typedef enum logic [2:0] {
    ST_SETTLE  = SEQ_SETTLE,
    ST_FEED    = SEQ_FEED,
    ST_DRAIN   = SEQ_DRAIN,
    ST_DISPLAY = SEQ_DISPLAY,
    ST_BYPASS  = SEQ_BYPASS,
    ST_ERROR   = SEQ_ERROR
  } seq_state_e;

  // Switch configuration as seen by the sequencer.
  typedef struct packed {
    logic [3:0] alg;    // one-hot algorithm select, 0 = bypass
    logic [1:0] scale;  // zoom factor select
  } cfg_t;

endpackage

// File: rtl/cfg_change_detect.sv
// -----------------------------------------------------------------------------
// cfg_change_detect
// Registers the switch configuration every cycle and flags a one-cycle
// cfg_change_o whenever the live input differs from the registered copy.
// The first cycle after reset never flags a change, so the power-up switch
// position does not look like a user edit.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   cfg_i         live {alg, scale} switch configuration
//   cfg_change_o  combinational pulse, high while cfg_i != registered copy
// -----------------------------------------------------------------------------
module cfg_change_detect
  import img_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  cfg_t cfg_i,
  output logic cfg_change_o
);

  cfg_t cfg_q;
  logic primed_q;

  // primed_q stands in for "reset to the current input": until the first
  // clock after reset has captured cfg_i, the comparison is masked. This
  // avoids an asynchronous load of a data value into the flops.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q    <= '0;
      primed_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_i;
      primed_q <= 1'b1;
    end
  end

  assign cfg_change_o = primed_q && (cfg_i != cfg_q);

endmodule

// File: rtl/frame_proc_sequencer.sv
// -----------------------------------------------------------------------------
// frame_proc_sequencer
// Central controller of the image path. After reset, a soft restart or any
// switch change, the coprocessor is held in reset for SETTLE_CYCLES+1 clocks.
// It then either streams the source image out of ROM into the coprocessor
// (FEED), waits for the tail of the output stream (DRAIN) and hands the
// frame buffer to VGA (DISPLAY), or, with no algorithm selected, leaves the
// VGA showing the ROM directly (BYPASS).
//
// Optional feature, macro SEQ_WATCHDOG_EN: a 24-bit stall counter in
// FEED/DRAIN; 2^24-1 consecutive idle cycles force the ERROR state and set
// the sticky wdog_err output.
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   soft_rst          synchronous restart request (highest priority)
//   cfg_alg/cfg_scale algorithm one-hot select (0 = bypass), zoom select
//   cp_resetn/cp_start coprocessor reset (active low) and start
//   cp_in_ready       coprocessor accepts the pixel at rom_addr this cycle
//   cp_out_valid      coprocessor presents an output pixel this cycle
//   cp_done           coprocessor finished the frame
//   rom_addr          source ROM read address
//   ram_waddr/ram_wren frame-buffer write address / enable (enable is
//                     combinational, same cycle as cp_out_valid)
//   show_processed    1 = VGA reads the frame buffer, 0 = VGA reads ROM
//   busy              high in SETTLE/FEED/DRAIN
//   overflow          sticky, last frame-buffer location has been written
//   seq_state         current state encoding
//   wdog_err          (SEQ_WATCHDOG_EN only) sticky stall error
// -----------------------------------------------------------------------------
module frame_proc_sequencer
  import img_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int SRC_PIXELS     = DEF_SRC_PIXELS,
  parameter int MAX_OUT_PIXELS = DEF_MAX_OUT_PIXELS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_rst,
  input  logic [3:0]        cfg_alg,
  input  logic [1:0]        cfg_scale,
  output logic              cp_resetn,
  output logic              cp_start,
  input  logic              cp_in_ready,
  input  logic              cp_out_valid,
  input  logic              cp_done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_wren,
  output logic              show_processed,
  output logic              busy,
  output logic              overflow,
  output logic [2:0]        seq_state
`ifdef SEQ_WATCHDOG_EN
  ,
  output logic              wdog_err
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ADDR_W-1:0] SRC_LAST    = ADDR_W'(SRC_PIXELS - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST    = ADDR_W'(MAX_OUT_PIXELS - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  settle_q, settle_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic              overflow_q, overflow_d;
  logic              cp_resetn_q, cp_start_q, show_q, busy_q;
  logic              cfg_change, restart, active, wr_en;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = '1;
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_q, wdog_err_d;
`endif

  cfg_change_detect u_cfg_change_detect (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_i        ('{alg: cfg_alg, scale: cfg_scale}),
    .cfg_change_o (cfg_change)
  );

  assign restart = soft_rst || cfg_change;
  assign active  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  // Writes stop once the last frame-buffer location has been used.
  assign wr_en   = active && cp_out_valid && !overflow_q;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    rom_addr_d  = rom_addr_q;
    ram_waddr_d = ram_waddr_q;
    overflow_d  = overflow_q;

    // Write address advances after each write and saturates on the last
    // location, where the write still happens but flags overflow.
    if (wr_en) begin
      if (ram_waddr_q == OUT_LAST) overflow_d  = 1'b1;
      else                         ram_waddr_d = ram_waddr_q + ADDR_W'(1);
    end

    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == '0) state_d = (cfg_alg == 4'd0) ? ST_BYPASS : ST_FEED;
        else                settle_d = settle_q - CNT_W'(1);
      end
      ST_FEED: begin
        if (cp_in_ready) begin
          // The last source pixel is accepted in place: no wrap.
          if (rom_addr_q == SRC_LAST) state_d = ST_DRAIN;
          else                        rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
        if (cp_done) state_d = ST_DISPLAY;
      end
      ST_DRAIN: begin
        if (cp_done) state_d = ST_DISPLAY;
      end
      default: ;  // DISPLAY, BYPASS, ERROR wait for a restart
    endcase

`ifdef SEQ_WATCHDOG_EN
    wdog_err_d = wdog_err_q;
    wdog_cnt_d = '0;
    if (active && !(cp_in_ready || cp_out_valid || cp_done)) begin
      wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
      if (wdog_cnt_d == WDOG_LIMIT) begin
        state_d    = ST_ERROR;
        wdog_err_d = 1'b1;
      end
    end
`endif

    // Restart overrides everything, including a SETTLE already in progress.
    if (restart) begin
      state_d     = ST_SETTLE;
      settle_d    = SETTLE_LOAD;
      rom_addr_d  = '0;
      ram_waddr_d = '0;
      overflow_d  = 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdog_cnt_d  = '0;
      wdog_err_d  = 1'b0;
`endif
    end
  end

  // Control outputs are decoded from the next state and registered, so they
  // change on the same edge as the state itself. The coprocessor stays out
  // of reset in DISPLAY so its last results are left undisturbed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_SETTLE;
      settle_q    <= SETTLE_LOAD;
      rom_addr_q  <= '0;
      ram_waddr_q <= '0;
      overflow_q  <= 1'b0;
      cp_resetn_q <= 1'b0;
      cp_start_q  <= 1'b0;
      show_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      rom_addr_q  <= rom_addr_d;
      ram_waddr_q <= ram_waddr_d;
      overflow_q  <= overflow_d;
      cp_resetn_q <= (state_d == ST_FEED) || (state_d == ST_DRAIN) ||
                     (state_d == ST_DISPLAY);
      cp_start_q  <= (state_d == ST_FEED) || (state_d == ST_DRAIN);
      show_q      <= (state_d == ST_DISPLAY);
      busy_q      <= (state_d == ST_SETTLE) || (state_d == ST_FEED) ||
                     (state_d == ST_DRAIN);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`endif

  assign cp_resetn      = cp_resetn_q;
  assign cp_start       = cp_start_q;
  assign rom_addr       = rom_addr_q;
  assign ram_waddr      = ram_waddr_q;
  assign ram_wren       = wr_en;
  assign show_processed = show_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_frame_proc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_proc_sequencer
// Two sequencers: dut_a with the full-size defaults and dut_b with a tiny
// frame buffer (8 pixels) to reach overflow quickly. Expected frame-buffer
// writes are queued as stimulus is issued; a monitor on the falling edge
// pops and compares whenever a DUT asserts ram_wren.
// -----------------------------------------------------------------------------
module tb_frame_proc_sequencer;

  localparam int S_SETTLE = 0, S_FEED = 1, S_DRAIN = 2, S_DISPLAY = 3,
                 S_BYPASS = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // dut_a signals
  logic        a_soft, a_ready, a_valid, a_done;
  logic [3:0]  a_alg;
  logic [1:0]  a_scale;
  logic        a_cp_resetn, a_cp_start, a_wren, a_show, a_busy, a_ovf;
  logic [18:0] a_rom, a_waddr;
  logic [2:0]  a_state;
  // dut_b signals
  logic        b_soft, b_ready, b_valid, b_done;
  logic [3:0]  b_alg;
  logic [1:0]  b_scale;
  logic        b_cp_resetn, b_cp_start, b_wren, b_show, b_busy, b_ovf;
  logic [18:0] b_rom, b_waddr;
  logic [2:0]  b_state;
`ifdef SEQ_WATCHDOG_EN
  logic        a_wdog, b_wdog;
`endif

  int errors = 0;
  int checks = 0;
  int exp_a[$];
  int exp_b[$];

  frame_proc_sequencer dut_a (
    .clk(clk), .resetn(resetn), .soft_rst(a_soft), .cfg_alg(a_alg),
    .cfg_scale(a_scale), .cp_resetn(a_cp_resetn), .cp_start(a_cp_start),
    .cp_in_ready(a_ready), .cp_out_valid(a_valid), .cp_done(a_done),
    .rom_addr(a_rom), .ram_waddr(a_waddr), .ram_wren(a_wren),
    .show_processed(a_show), .busy(a_busy), .overflow(a_ovf),
    .seq_state(a_state)
`ifdef SEQ_WATCHDOG_EN
    , .wdog_err(a_wdog)
`endif
  );

  frame_proc_sequencer #(
    .SRC_PIXELS(4), .MAX_OUT_PIXELS(8), .SETTLE_CYCLES(2)
  ) dut_b (
    .clk(clk), .resetn(resetn), .soft_rst(b_soft), .cfg_alg(b_alg),
    .cfg_scale(b_scale), .cp_resetn(b_cp_resetn), .cp_start(b_cp_start),
    .cp_in_ready(b_ready), .cp_out_valid(b_valid), .cp_done(b_done),
    .rom_addr(b_rom), .ram_waddr(b_waddr), .ram_wren(b_wren),
    .show_processed(b_show), .busy(b_busy), .overflow(b_ovf),
    .seq_state(b_state)
`ifdef SEQ_WATCHDOG_EN
    , .wdog_err(b_wdog)
`endif
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor / scoreboard.
  int e_a, e_b;
  always @(negedge clk) begin
    if (a_wren === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a_unexpected: write at addr %0d, none expected", a_waddr);
      end else begin
        e_a = exp_a.pop_front();
        if (a_waddr !== 19'(e_a)) begin
          errors++;
          $display("FAIL wr_a_addr: got %0d, expected %0d", a_waddr, e_a);
        end
      end
    end
    if (b_wren === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b_unexpected: write at addr %0d, none expected", b_waddr);
      end else begin
        e_b = exp_b.pop_front();
        if (b_waddr !== 19'(e_b)) begin
          errors++;
          $display("FAIL wr_b_addr: got %0d, expected %0d", b_waddr, e_b);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    {a_soft, a_ready, a_valid, a_done} = '0;
    {b_soft, b_ready, b_valid, b_done} = '0;
    a_alg = 4'b0001; a_scale = 2'd0;
    b_alg = 4'b0001; b_scale = 2'd0;
    repeat (3) tick();

    // ---- reset state ----
    check("rst_state", a_state, S_SETTLE);
    check("rst_cp_resetn", a_cp_resetn, 0);
    check("rst_cp_start", a_cp_start, 0);
    check("rst_rom", a_rom, 0);
    check("rst_waddr", a_waddr, 0);
    check("rst_wren", a_wren, 0);
    check("rst_show", a_show, 0);
    check("rst_busy", a_busy, 1);
    check("rst_ovf", a_ovf, 0);

    // ---- settle: 16 cycles, then FEED with cp_resetn rising ----
    resetn  = 1'b1;
    a_ready = 1'b1;
    check("settle_0", a_state, S_SETTLE);
    for (int i = 1; i <= 15; i++) begin
      tick();
      check("settle_n", a_state, S_SETTLE);
      check("settle_cp_resetn", a_cp_resetn, 0);
    end
    tick();
    check("feed_entry", a_state, S_FEED);
    check("feed_cp_resetn", a_cp_resetn, 1);
    check("feed_cp_start", a_cp_start, 1);
    check("feed_rom0", a_rom, 0);

    // ---- feed 19200 pixels while writing 76800 outputs ----
    a_valid = 1'b1;
    for (int j = 0; j < 76800; j++) begin
      exp_a.push_back(j);
      if (j == 76799) a_done = 1'b1;
      tick();
      if (j < 19300) begin
        check("feed_rom", a_rom, (j + 1 < 19199) ? j + 1 : 19199);
        check("feed_state", a_state, (j < 19199) ? S_FEED : S_DRAIN);
      end
      if (j % 10000 == 0) check("feed_waddr", a_waddr, j + 1);
    end
    check("disp_state", a_state, S_DISPLAY);
    check("disp_waddr", a_waddr, 76800);
    check("disp_show", a_show, 1);
    check("disp_busy", a_busy, 0);
    check("disp_cp_start", a_cp_start, 0);
    check("disp_ovf", a_ovf, 0);
    // valid and done in DISPLAY are ignored (monitor flags any write)
    tick();
    check("disp_hold", a_state, S_DISPLAY);
    a_valid = 1'b0; a_done = 1'b0;

    // ---- soft restart from DISPLAY ----
    a_soft = 1'b1;
    tick();
    a_soft = 1'b0;
    check("srst_state", a_state, S_SETTLE);
    check("srst_waddr", a_waddr, 0);
    check("srst_show", a_show, 0);
    check("srst_busy", a_busy, 1);
    repeat (15) tick();
    check("srst_settle_end", a_state, S_SETTLE);
    tick();
    check("srst_feed", a_state, S_FEED);

    // ---- cfg change + soft_rst mid-FEED at rom_addr 5000 ----
    for (int k = 0; k < 5000; k++) begin
      a_valid = (k < 3);
      if (k < 3) exp_a.push_back(k);
      tick();
    end
    a_valid = 1'b0;
    check("mid_rom", a_rom, 5000);
    check("mid_waddr", a_waddr, 3);
    a_alg  = 4'b0010;
    a_soft = 1'b1;
    tick();
    a_soft = 1'b0;
    check("chg_state", a_state, S_SETTLE);
    check("chg_rom", a_rom, 0);
    check("chg_waddr", a_waddr, 0);
    check("chg_cp_resetn", a_cp_resetn, 0);
    check("chg_cp_start", a_cp_start, 0);

    // ---- change mid-SETTLE reloads counter; alg 0 -> BYPASS ----
    repeat (5) tick();
    a_alg = 4'b0000;
    tick();
    for (int i = 0; i < 15; i++) begin
      tick();
      check("reload_settle", a_state, S_SETTLE);
    end
    tick();
    check("byp_state", a_state, S_BYPASS);
    check("byp_show", a_show, 0);
    check("byp_cp_start", a_cp_start, 0);
    check("byp_cp_resetn", a_cp_resetn, 0);
    check("byp_busy", a_busy, 0);
    a_valid = 1'b1; a_done = 1'b1;
    tick();
    a_valid = 1'b0; a_done = 1'b0;
    check("byp_hold", a_state, S_BYPASS);

    // ---- dut_b: 8-pixel frame buffer, 10 output pulses ----
    b_soft = 1'b1;
    tick();
    b_soft = 1'b0;
    check("b_settle", b_state, S_SETTLE);
    tick(); tick();
    check("b_settle_end", b_state, S_SETTLE);
    tick();
    check("b_feed", b_state, S_FEED);
    b_ready = 1'b1;
    b_valid = 1'b1;
    for (int p = 0; p < 10; p++) begin
      if (p < 8) exp_b.push_back(p);
      else check("b_wren_low", b_wren, 0);
      tick();
      check("b_rom", b_rom, (p + 1 < 3) ? p + 1 : 3);
      check("b_state", b_state, (p < 3) ? S_FEED : S_DRAIN);
      check("b_waddr", b_waddr, (p + 1 < 7) ? p + 1 : 7);
      check("b_ovf", b_ovf, (p >= 7) ? 1 : 0);
    end
    b_valid = 1'b0;
    b_done  = 1'b1;
    tick();
    b_done  = 1'b0;
    check("b_display", b_state, S_DISPLAY);
    check("b_ovf_sticky", b_ovf, 1);
    b_soft = 1'b1;
    tick();
    b_soft = 1'b0;
    check("b_ovf_cleared", b_ovf, 0);

`ifdef SEQ_WATCHDOG_EN
    check("a_wdog_clear", a_wdog, 0);
    check("b_wdog_clear", b_wdog, 0);
`endif
    tick();
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
